// File: rtl/hilo_reg_pkg.sv
// rtl/hilo_reg_pkg.sv - shared HI/LO write-enable encodings and pending-entry type
package hilo_reg_pkg;

  // {hi_we, lo_we} encodings shared with the ALU
  localparam logic [1:0] HILO_WE_NONE = 2'b00;
  localparam logic [1:0] HILO_WE_LO   = 2'b01;
  localparam logic [1:0] HILO_WE_HI   = 2'b10;
  localparam logic [1:0] HILO_WE_BOTH = 2'b11;

  // One pending HI/LO result waiting in MEM for its commit decision
  typedef struct packed {
    logic        valid;
    logic [1:0]  we;
    logic [63:0] data;
  } hilo_pend_t;

  localparam int HILO_PEND_W = $bits(hilo_pend_t);

  localparam hilo_pend_t HILO_PEND_EMPTY = '{valid: 1'b0, we: HILO_WE_NONE, data: 64'h0};

  // Merge a pending entry over the committed value, half by half
  function automatic logic [63:0] hilo_overlay(input logic [63:0] base, input hilo_pend_t p);
    logic [63:0] r;
    r = base;
    if (p.we[1]) r[63:32] = p.data[63:32];
    if (p.we[0]) r[31:0]  = p.data[31:0];
    return r;
  endfunction

endpackage

// File: rtl/hilo_reg_if.sv
// rtl/hilo_reg_if.sv - pipeline-side bundle between EX/MEM control and the HI/LO block
interface hilo_reg_if;

  logic        stallM;
  logic        flushM;
  logic        exceptM;
  logic [1:0]  hilo_weE;
  logic [63:0] alu_outE;
  logic        hilo_readE;
  logic [63:0] hilo_o;
  logic        hilo_stallE;
  logic        hilo_commitW;

  // Pipeline control / ALU side
  modport master (
    output stallM, flushM, exceptM, hilo_weE, alu_outE, hilo_readE,
    input  hilo_o, hilo_stallE, hilo_commitW
  );

  // HI/LO register block side
  modport slave (
    input  stallM, flushM, exceptM, hilo_weE, alu_outE, hilo_readE,
    output hilo_o, hilo_stallE, hilo_commitW
  );

endinterface

// File: rtl/hilo_pending_buf.sv
// rtl/hilo_pending_buf.sv - one-entry MEM-stage buffer with kill/hold/commit/capture
module hilo_pending_buf
  import hilo_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        except_i,
  input  logic [1:0]  we_i,
  input  logic [63:0] data_i,
  output hilo_pend_t  pend_o,
  output logic        commit_o
);

  hilo_pend_t pend_q, pend_d;

  // A valid entry commits when MEM advances cleanly this edge
  assign commit_o = pend_q.valid & ~except_i & ~stall_i;
  assign pend_o   = pend_q;

  // Next entry: exception kills even under stall, stall holds, else capture EX
  always_comb begin
    pend_d = pend_q;
    if (except_i) begin
      pend_d = HILO_PEND_EMPTY;
    end else if (!stall_i) begin
      if (flush_i) begin
        pend_d = HILO_PEND_EMPTY;
      end else begin
        pend_d.valid = |we_i;
        pend_d.we    = we_i;
        pend_d.data  = data_i;
      end
    end
  end

  // Pending entry register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= HILO_PEND_EMPTY;
    else     pend_q <= pend_d;
  end

endmodule

// File: rtl/hilo_reg.sv
// rtl/hilo_reg.sv - architectural HI/LO pair with MEM-stage pending entry; optional bypass via HILO_BYPASS_EN
module hilo_reg
  import hilo_reg_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  hilo_reg_if.slave bus
);

  hilo_pend_t  pend;
  logic        commit;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        commit_w_q;

  hilo_pending_buf u_pend (
    .clk      (clk),
    .rst      (rst),
    .stall_i  (bus.stallM),
    .flush_i  (bus.flushM),
    .except_i (bus.exceptM),
    .we_i     (bus.hilo_weE),
    .data_i   (bus.alu_outE),
    .pend_o   (pend),
    .commit_o (commit)
  );

  // Committed value takes each half the pending entry enables
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit && pend.we[1]) hi_d = pend.data[63:32];
    if (commit && pend.we[0]) lo_d = pend.data[31:0];
  end

  // Architectural HI/LO and the registered commit pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q       <= 32'h0;
      lo_q       <= 32'h0;
      commit_w_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      commit_w_q <= commit;
    end
  end

  assign bus.hilo_commitW = commit_w_q;

`ifdef HILO_BYPASS_EN
  // Forward the pending entry unless it is being killed this cycle
  always_comb begin
    bus.hilo_o = {hi_q, lo_q};
    if (pend.valid && !bus.exceptM) bus.hilo_o = hilo_overlay({hi_q, lo_q}, pend);
  end
  assign bus.hilo_stallE = 1'b0;
`else
  // No forwarding: readers wait until the pending entry leaves MEM
  always_comb begin
    bus.hilo_o = {hi_q, lo_q};
  end
  assign bus.hilo_stallE = bus.hilo_readE & pend.valid;
`endif

endmodule

// File: tb/tb_hilo_reg.sv
// tb/tb_hilo_reg.sv - directed self-checking bench for hilo_reg
module tb_hilo_reg;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  hilo_reg_if bus();

  hilo_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stallM     = 1'b0;
    bus.flushM     = 1'b0;
    bus.exceptM    = 1'b0;
    bus.hilo_weE   = 2'b00;
    bus.alu_outE   = 64'h0;
    bus.hilo_readE = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (bus.hilo_o !== 64'h0) begin errors++; $display("FAIL reset_hilo got=%h exp=0", bus.hilo_o); end
    vectors++; if (bus.hilo_stallE !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.hilo_stallE); end
    vectors++; if (bus.hilo_commitW !== 1'b0) begin errors++; $display("FAIL reset_commit got=%b exp=0", bus.hilo_commitW); end
  endtask

  task automatic test_mult();
    logic [63:0] exp;
    bus.hilo_weE = 2'b11; bus.alu_outE = 64'h00000001_FFFFFFFE;
    step();
    idle_inputs();
`ifdef HILO_BYPASS_EN
    exp = 64'h00000001_FFFFFFFE;
`else
    exp = 64'h0;
`endif
    vectors++; if (bus.hilo_o !== exp) begin errors++; $display("FAIL mult_e1_hilo got=%h exp=%h", bus.hilo_o, exp); end
    vectors++; if (dut.pend.valid !== 1'b1) begin errors++; $display("FAIL mult_e1_pvalid got=%b exp=1", dut.pend.valid); end
    vectors++; if (bus.hilo_commitW !== 1'b0) begin errors++; $display("FAIL mult_e1_commit got=%b exp=0", bus.hilo_commitW); end
    step();
    vectors++; if (bus.hilo_o !== 64'h00000001_FFFFFFFE) begin errors++; $display("FAIL mult_e2_hilo got=%h exp=00000001fffffffe", bus.hilo_o); end
    vectors++; if (bus.hilo_commitW !== 1'b1) begin errors++; $display("FAIL mult_e2_commit got=%b exp=1", bus.hilo_commitW); end
    step();
    vectors++; if (bus.hilo_commitW !== 1'b0) begin errors++; $display("FAIL mult_e3_commit got=%b exp=0", bus.hilo_commitW); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    bus.hilo_weE = 2'b10; bus.alu_outE = 64'hDEADBEEF_11111111;
    step();
    bus.hilo_weE = 2'b01; bus.alu_outE = 64'h22222222_12345678;
    step();
    idle_inputs();
`ifdef HILO_BYPASS_EN
    exp = 64'hDEADBEEF_12345678;
`else
    exp = 64'hDEADBEEF_FFFFFFFE;
`endif
    vectors++; if (bus.hilo_o !== exp) begin errors++; $display("FAIL b2b_mid_hilo got=%h exp=%h", bus.hilo_o, exp); end
    vectors++; if (bus.hilo_commitW !== 1'b1) begin errors++; $display("FAIL b2b_mid_commit got=%b exp=1", bus.hilo_commitW); end
    step();
    vectors++; if (bus.hilo_o !== 64'hDEADBEEF_12345678) begin errors++; $display("FAIL b2b_end_hilo got=%h exp=deadbeef12345678", bus.hilo_o); end
    vectors++; if (bus.hilo_commitW !== 1'b1) begin errors++; $display("FAIL b2b_end_commit got=%b exp=1", bus.hilo_commitW); end
    step();
  endtask

  task automatic test_exception();
    bus.hilo_weE = 2'b11; bus.alu_outE = 64'h00000003_00000007;
    step();
    idle_inputs();
    bus.exceptM = 1'b1;
    #1;
    vectors++; if (bus.hilo_o !== 64'hDEADBEEF_12345678) begin errors++; $display("FAIL exc_overlay_hilo got=%h exp=deadbeef12345678", bus.hilo_o); end
    step();
    bus.exceptM = 1'b0;
    vectors++; if (dut.pend.valid !== 1'b0) begin errors++; $display("FAIL exc_pvalid got=%b exp=0", dut.pend.valid); end
    vectors++; if (bus.hilo_commitW !== 1'b0) begin errors++; $display("FAIL exc_commit got=%b exp=0", bus.hilo_commitW); end
    step();
    vectors++; if (bus.hilo_o !== 64'hDEADBEEF_12345678) begin errors++; $display("FAIL exc_hilo got=%h exp=deadbeef12345678", bus.hilo_o); end
    vectors++; if (bus.hilo_commitW !== 1'b0) begin errors++; $display("FAIL exc_commit2 got=%b exp=0", bus.hilo_commitW); end
  endtask

  task automatic test_stall();
    logic [63:0] exp;
    bus.hilo_weE = 2'b11; bus.alu_outE = 64'hAAAA0000_5555FFFF;
    step();
    idle_inputs();
    bus.stallM = 1'b1;
    bus.hilo_weE = 2'b11; bus.alu_outE = 64'h99999999_99999999;
`ifdef HILO_BYPASS_EN
    exp = 64'hAAAA0000_5555FFFF;
`else
    exp = 64'hDEADBEEF_12345678;
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (bus.hilo_o !== exp) begin errors++; $display("FAIL stall%0d_hilo got=%h exp=%h", i, bus.hilo_o, exp); end
      vectors++; if (bus.hilo_commitW !== 1'b0) begin errors++; $display("FAIL stall%0d_commit got=%b exp=0", i, bus.hilo_commitW); end
      vectors++; if (dut.pend.valid !== 1'b1) begin errors++; $display("FAIL stall%0d_pvalid got=%b exp=1", i, dut.pend.valid); end
    end
    idle_inputs();
    step();
    vectors++; if (bus.hilo_commitW !== 1'b1) begin errors++; $display("FAIL stall_rel_commit got=%b exp=1", bus.hilo_commitW); end
    vectors++; if (bus.hilo_o !== 64'hAAAA0000_5555FFFF) begin errors++; $display("FAIL stall_rel_hilo got=%h exp=aaaa00005555ffff", bus.hilo_o); end
    step();
  endtask

  task automatic test_stall_except();
    bus.hilo_weE = 2'b11; bus.alu_outE = 64'h0BAD0BAD_0BAD0BAD;
    step();
    idle_inputs();
    bus.stallM = 1'b1;
    step();
    bus.exceptM = 1'b1;
    step();
    vectors++; if (dut.pend.valid !== 1'b0) begin errors++; $display("FAIL stexc_pvalid got=%b exp=0", dut.pend.valid); end
    vectors++; if (bus.hilo_commitW !== 1'b0) begin errors++; $display("FAIL stexc_commit got=%b exp=0", bus.hilo_commitW); end
    idle_inputs();
    step();
    vectors++; if (bus.hilo_commitW !== 1'b0) begin errors++; $display("FAIL stexc_commit2 got=%b exp=0", bus.hilo_commitW); end
    vectors++; if (bus.hilo_o !== 64'hAAAA0000_5555FFFF) begin errors++; $display("FAIL stexc_hilo got=%h exp=aaaa00005555ffff", bus.hilo_o); end
  endtask

  task automatic test_stall_read();
    logic exp_st;
`ifdef HILO_BYPASS_EN
    exp_st = 1'b0;
`else
    exp_st = 1'b1;
`endif
    bus.hilo_weE = 2'b11; bus.alu_outE = 64'h13572468_9ABCDEF0;
    step();
    idle_inputs();
    bus.hilo_readE = 1'b1;
    bus.stallM = 1'b1;
    #1;
    vectors++; if (bus.hilo_stallE !== exp_st) begin errors++; $display("FAIL rd_stall0 got=%b exp=%b", bus.hilo_stallE, exp_st); end
    step();
    vectors++; if (bus.hilo_stallE !== exp_st) begin errors++; $display("FAIL rd_stall1 got=%b exp=%b", bus.hilo_stallE, exp_st); end
    bus.stallM = 1'b0;
    step();
    vectors++; if (bus.hilo_stallE !== 1'b0) begin errors++; $display("FAIL rd_stall_done got=%b exp=0", bus.hilo_stallE); end
    vectors++; if (bus.hilo_o !== 64'h13572468_9ABCDEF0) begin errors++; $display("FAIL rd_hilo got=%h exp=135724689abcdef0", bus.hilo_o); end
    idle_inputs();
    step();
  endtask

  task automatic test_flush();
    bus.hilo_weE = 2'b11; bus.alu_outE = 64'h0F0F0F0F_F0F0F0F0;
    step();
    bus.flushM = 1'b1; bus.hilo_weE = 2'b11; bus.alu_outE = 64'h77777777_77777777;
    step();
    idle_inputs();
    vectors++; if (bus.hilo_commitW !== 1'b1) begin errors++; $display("FAIL flush_commit got=%b exp=1", bus.hilo_commitW); end
    vectors++; if (dut.pend.valid !== 1'b0) begin errors++; $display("FAIL flush_pvalid got=%b exp=0", dut.pend.valid); end
    vectors++; if (bus.hilo_o !== 64'h0F0F0F0F_F0F0F0F0) begin errors++; $display("FAIL flush_hilo got=%h exp=0f0f0f0ff0f0f0f0", bus.hilo_o); end
    step();
    vectors++; if (bus.hilo_commitW !== 1'b0) begin errors++; $display("FAIL flush_commit2 got=%b exp=0", bus.hilo_commitW); end
    vectors++; if (bus.hilo_o !== 64'h0F0F0F0F_F0F0F0F0) begin errors++; $display("FAIL flush_hilo2 got=%h exp=0f0f0f0ff0f0f0f0", bus.hilo_o); end
  endtask

  task automatic test_async_reset();
    bus.hilo_weE = 2'b11; bus.alu_outE = 64'hFEEDFACE_CAFEF00D;
    step();
    idle_inputs();
    bus.stallM = 1'b1;
    step();
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (bus.hilo_o !== 64'h0) begin errors++; $display("FAIL arst_hilo got=%h exp=0", bus.hilo_o); end
    vectors++; if (dut.pend.valid !== 1'b0) begin errors++; $display("FAIL arst_pvalid got=%b exp=0", dut.pend.valid); end
    vectors++; if (bus.hilo_stallE !== 1'b0) begin errors++; $display("FAIL arst_stall got=%b exp=0", bus.hilo_stallE); end
    bus.stallM = 1'b0;
    #2;
    rst = 1'b0;
    step();
    vectors++; if (bus.hilo_commitW !== 1'b0) begin errors++; $display("FAIL arst_commit got=%b exp=0", bus.hilo_commitW); end
    vectors++; if (bus.hilo_o !== 64'h0) begin errors++; $display("FAIL arst_hilo2 got=%h exp=0", bus.hilo_o); end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    step();
    test_reset();
    test_mult();
    test_back_to_back();
    test_exception();
    test_stall();
    test_stall_except();
    test_stall_read();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
